// File: rtl/s_core_boot_ctrl.sv
// s_core_boot_ctrl: sequences s_core setup from a valid/ready command stream (IMEM/REG/PC/GO), releases setup after a settle window, returns to setup on halt.
// Ports: clk, rst_n (async active-low); i_cmd_valid/o_cmd_ready/i_cmd_type/i_cmd_addr/i_cmd_data command stream;
// i_halt abort; o_setup, o_inst_mem_addr/data, o_inst_we, o_load_reg_addr/data, o_reg_we, o_pc_start_addr to s_core;
// o_running, o_err (sticky x0 write drop), o_timeout (run-limit pulse, only with S_CORE_RUN_LIMIT_EN defined).
module s_core_boot_ctrl #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 5,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RUN       = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_type,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  input  logic              i_halt,
  output logic              o_setup,
  output logic [ADDR_W-1:0] o_inst_mem_addr,
  output logic [DATA_W-1:0] o_inst_mem_data,
  output logic              o_inst_we,
  output logic [REG_AW-1:0] o_load_reg_addr,
  output logic [DATA_W-1:0] o_load_reg_data,
  output logic              o_reg_we,
  output logic [ADDR_W-1:0] o_pc_start_addr,
  output logic              o_running,
  output logic              o_err,
  output logic              o_timeout
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] cnt;
  logic acc, go, reg_cmd, reg_x0, run_exp;
  assign o_cmd_ready = state == IDLE;
  assign o_setup     = state != RUN;
  assign o_running   = state == RUN;
  assign acc         = i_cmd_valid && o_cmd_ready;
  assign go          = acc && i_cmd_type == 2'b11;
  assign reg_cmd     = acc && i_cmd_type == 2'b01;
  assign reg_x0      = i_cmd_addr[REG_AW-1:0] == '0;
`ifdef S_CORE_RUN_LIMIT_EN
  localparam int RW = $clog2(MAX_RUN + 1);
  logic [RW-1:0] run_cnt;
  // Halt has priority over expiry, so a halt on the limit edge suppresses the pulse.
  assign run_exp = state == RUN && !i_halt && run_cnt == RW'(MAX_RUN - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_cnt   <= '0;
      o_timeout <= 1'b0;
    end else begin
      run_cnt   <= (state == RUN) ? run_cnt + 1'b1 : '0;
      o_timeout <= run_exp;
    end
`else
  assign run_exp   = 1'b0;
  assign o_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = go ? SETTLE : IDLE;
      SETTLE:  state_nxt = i_halt ? IDLE : (cnt == '0) ? RUN : SETTLE;
      RUN:     state_nxt = (i_halt || run_exp) ? IDLE : RUN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt             <= '0;
      o_inst_mem_addr <= '0;
      o_inst_mem_data <= '0;
      o_inst_we       <= 1'b0;
      o_load_reg_addr <= '0;
      o_load_reg_data <= '0;
      o_reg_we        <= 1'b0;
      o_pc_start_addr <= '0;
      o_err           <= 1'b0;
    end else begin
      o_inst_we <= acc && i_cmd_type == 2'b00;
      o_reg_we  <= reg_cmd && !reg_x0;
      if (acc && i_cmd_type == 2'b00) begin
        o_inst_mem_addr <= i_cmd_addr;
        o_inst_mem_data <= i_cmd_data;
      end
      if (reg_cmd && !reg_x0) begin
        o_load_reg_addr <= i_cmd_addr[REG_AW-1:0];
        o_load_reg_data <= i_cmd_data;
      end
      if (acc && i_cmd_type == 2'b10) o_pc_start_addr <= i_cmd_data[ADDR_W-1:0];
      if (reg_cmd && reg_x0) o_err <= 1'b1;
      else if (go) o_err <= 1'b0;
      if (go) cnt <= SW'(SETTLE_CYCLES - 1);
      else if (state == SETTLE && cnt != '0) cnt <= cnt - 1'b1;
    end
endmodule

// File: tb/tb_s_core_boot_ctrl.sv
// tb_s_core_boot_ctrl: directed self-checking bench for s_core_boot_ctrl (SETTLE_CYCLES=2, MAX_RUN=8).
module tb_s_core_boot_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_type = 2'b00;
  logic [31:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_data = '0;
  logic        i_halt = 1'b0;
  logic        o_setup, o_inst_we, o_reg_we, o_running, o_err, o_timeout;
  logic [31:0] o_inst_mem_addr, o_inst_mem_data, o_load_reg_data, o_pc_start_addr;
  logic [4:0]  o_load_reg_addr;
  int checks = 0;
  int errors = 0;
  int run_cycles;
  int to_pulses;

  s_core_boot_ctrl #(.SETTLE_CYCLES(2), .MAX_RUN(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_type(i_cmd_type), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_halt(i_halt),
    .o_setup(o_setup), .o_inst_mem_addr(o_inst_mem_addr), .o_inst_mem_data(o_inst_mem_data),
    .o_inst_we(o_inst_we), .o_load_reg_addr(o_load_reg_addr), .o_load_reg_data(o_load_reg_data),
    .o_reg_we(o_reg_we), .o_pc_start_addr(o_pc_start_addr), .o_running(o_running),
    .o_err(o_err), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    i_cmd_valid = 1'b1;
    i_cmd_type  = t;
    i_cmd_addr  = a;
    i_cmd_data  = d;
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    drive(t, a, d);
    step();
    i_cmd_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_setup", o_setup, 1);
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_running", o_running, 0);
    chk("rst_we", {o_inst_we, o_reg_we, o_err, o_timeout}, 0);
    chk("rst_pc", o_pc_start_addr, 0);
    chk("rst_iaddr", o_inst_mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // Back-to-back IMEM then REG
    drive(2'b00, 32'h4, 32'h0012_7413);
    chk("b2b_ready0", o_cmd_ready, 1);
    step();
    chk("imem_we", o_inst_we, 1);
    chk("imem_addr", o_inst_mem_addr, 32'h4);
    chk("imem_data", o_inst_mem_data, 32'h0012_7413);
    chk("imem_regwe", o_reg_we, 0);
    drive(2'b01, 32'h4, 32'h1);
    chk("b2b_ready1", o_cmd_ready, 1);
    step();
    i_cmd_valid = 1'b0;
    chk("reg_inst_we", o_inst_we, 0);
    chk("reg_we", o_reg_we, 1);
    chk("reg_addr", o_load_reg_addr, 4);
    chk("reg_data", o_load_reg_data, 1);
    chk("imem_hold", o_inst_mem_addr, 32'h4);
    step();
    chk("reg_we_end", o_reg_we, 0);
    // REG write to x0 is dropped and flags the error
    send(2'b01, 32'h0, 32'hFFFF);
    chk("x0_we", o_reg_we, 0);
    chk("x0_err", o_err, 1);
    chk("x0_data", o_load_reg_data, 1);
    // Halt is ignored in IDLE; PC command still accepted
    i_halt = 1'b1;
    send(2'b10, 32'h0, 32'h10);
    i_halt = 1'b0;
    chk("idle_halt_pc", o_pc_start_addr, 32'h10);
    chk("idle_halt_ready", o_cmd_ready, 1);
    send(2'b10, 32'h0, 32'h4);
    chk("pc_last", o_pc_start_addr, 32'h4);
    // GO at edge N
    send(2'b11, 32'h0, 32'h0);
    chk("go_ready", o_cmd_ready, 0);
    chk("go_setup", o_setup, 1);
    chk("go_run0", o_running, 0);
    chk("go_err_clr", o_err, 0);
    drive(2'b00, 32'h8, 32'hDEAD);
    step();
    chk("n1_setup", o_setup, 1);
    chk("n1_ready", o_cmd_ready, 0);
    step();
    chk("n2_setup", o_setup, 0);
    chk("n2_running", o_running, 1);
    chk("n2_pc", o_pc_start_addr, 32'h4);
    chk("n2_ready", o_cmd_ready, 0);
    chk("stall_we", o_inst_we, 0);
    chk("stall_addr", o_inst_mem_addr, 32'h4);
    i_cmd_valid = 1'b0;
    repeat (4) step();
    chk("run5_running", o_running, 1);
    i_halt = 1'b1;
    step();
    i_halt = 1'b0;
    chk("halt_run_setup", o_setup, 1);
    chk("halt_run_running", o_running, 0);
    chk("halt_run_ready", o_cmd_ready, 1);
    chk("halt_run_to", o_timeout, 0);
    // Halt during SETTLE
    send(2'b11, 32'h0, 32'h0);
    i_halt = 1'b1;
    step();
    i_halt = 1'b0;
    chk("halt_set_running", o_running, 0);
    chk("halt_set_ready", o_cmd_ready, 1);
    step();
    chk("halt_set_running2", o_running, 0);
    chk("halt_set_setup", o_setup, 1);
    // Asynchronous reset mid-RUN
    send(2'b11, 32'h0, 32'h0);
    repeat (3) step();
    chk("pre_rst_running", o_running, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_setup", o_setup, 1);
    chk("async_running", o_running, 0);
    chk("async_pc", o_pc_start_addr, 0);
    chk("async_ready", o_cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
`ifdef S_CORE_RUN_LIMIT_EN
    send(2'b11, 32'h0, 32'h0);
    run_cycles = 0;
    to_pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (o_running) run_cycles++;
      if (o_timeout) to_pulses++;
    end
    chk("lim_run_cycles", run_cycles, 8);
    chk("lim_to_pulses", to_pulses, 1);
    chk("lim_idle", o_cmd_ready, 1);
    send(2'b11, 32'h0, 32'h0);
    repeat (9) step();
    chk("lim_last_running", o_running, 1);
    i_halt = 1'b1;
    step();
    i_halt = 1'b0;
    chk("lim_halt_to", o_timeout, 0);
    chk("lim_halt_running", o_running, 0);
    step();
    chk("lim_halt_to2", o_timeout, 0);
`else
    send(2'b11, 32'h0, 32'h0);
    to_pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (o_timeout) to_pulses++;
    end
    chk("nolim_running", o_running, 1);
    chk("nolim_to", to_pulses, 0);
    i_halt = 1'b1;
    step();
    i_halt = 1'b0;
    chk("nolim_halt", o_running, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
